// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle
// through a shared (WIDTH+1)-bit add/sub path. Latency: start accepted at
// edge E, result written and done pulsed at edge E+WIDTH+2.
// Optional feature macro: MULDIV_DIV0_FLAG_EN (early divide-by-zero exit
// with a div0 flag output).
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;        // bit1: divide, bit0: unsigned
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             neg_p_q, neg_p_d;  // product/quotient negate
    logic             neg_r_q, neg_r_d;  // remainder negate
    logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] sh_q, sh_d;        // multiplier or dividend, shifted out
    logic [W2-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             div0_q, div0_d, dz_q, dz_d;

    logic [WIDTH:0]   ax_s, ay_s;
    logic             sub_s;
    logic [WIDTH+1:0] sum_s;
    logic [W2-1:0]    prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, fix_hi_s, fix_lo_s;

    // Two's-complement magnitude for signed ops, pass-through otherwise.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Shared add/sub path: top carry set on subtract means no borrow.
    always_comb begin
        ax_s  = {(WIDTH+1){1'b0}};
        ay_s  = {(WIDTH+1){1'b0}};
        sub_s = 1'b0;
        if (op_q[1]) begin
            ax_s  = {acc_q[W2-1:WIDTH], sh_q[WIDTH-1]};
            ay_s  = {1'b0, opnd_q};
            sub_s = 1'b1;
        end else begin
            ax_s  = {1'b0, acc_q[W2-1:WIDTH]};
            ay_s  = sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}};
            sub_s = 1'b0;
        end
        sum_s = {1'b0, ax_s} + {1'b0, (sub_s ? ~ay_s : ay_s)} + {{(WIDTH+1){1'b0}}, sub_s};
    end

    // Sign correction of the finished accumulator into HI/LO candidates.
    always_comb begin
        prod_s = neg_p_q ? (~acc_q + W2'(1)) : acc_q;
        quo_s  = neg_p_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_s  = neg_r_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
        if (op_q[1]) begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end else begin
            fix_hi_s = prod_s[W2-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer next-state and datapath update; flush overrides everything.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        opnd_d  = opnd_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = div0_q;
        dz_d    = dz_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !op[2]) begin
                        div0_d  = 1'b0;
                        op_d    = op[1:0];
                        a_d     = a;
                        b_d     = b;
                        state_d = S_PREP;
                    end else if (start && op == 3'd4) begin
                        div0_d = 1'b0;
                        hi_d   = a;
                    end else if (start && op == 3'd5) begin
                        div0_d = 1'b0;
                        lo_d   = a;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PREP: begin
                    neg_p_d = !op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r_d = !op_q[0] && a_q[WIDTH-1];
                    acc_d   = {W2{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    dz_d    = 1'b0;
                    if (op_q[1]) begin
                        sh_d   = mag_f(a_q, !op_q[0]);
                        opnd_d = mag_f(b_q, !op_q[0]);
                    end else begin
                        sh_d   = mag_f(b_q, !op_q[0]);
                        opnd_d = mag_f(a_q, !op_q[0]);
                    end
`ifdef MULDIV_DIV0_FLAG_EN
                    if (op_q[1] && (b_q == {WIDTH{1'b0}})) begin
                        dz_d    = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        state_d = S_ITER;
                    end
`else
                    state_d = S_ITER;
`endif
                end
                S_ITER: begin
                    if (op_q[1]) begin
                        // Restoring step: keep the difference only when no borrow.
                        acc_d = {(sum_s[WIDTH+1] ? sum_s[WIDTH-1:0] : ax_s[WIDTH-1:0]),
                                 acc_q[WIDTH-2:0], sum_s[WIDTH+1]};
                        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {sum_s[WIDTH:0], acc_q[WIDTH-1:1]};
                        sh_d  = {1'b0, sh_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = S_FIX;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = S_ITER;
                    end
                end
                S_FIX: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (dz_q) begin
                        div0_d = 1'b1;
                        dz_d   = 1'b0;
                    end else begin
                        hi_d = fix_hi_s;
                        lo_d = fix_lo_s;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            opnd_q  <= {WIDTH{1'b0}};
            sh_q    <= {WIDTH{1'b0}};
            acc_q   <= {W2{1'b0}};
            cnt_q   <= {CW{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
            opnd_q  <= opnd_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
    assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed test-plan vectors with
// literal expectations, then randomized traffic compared every cycle
// against a cycle-count/arithmetic reference model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        div0;
    localparam bit DIV0_EN = 1'b1;
`else
    localparam bit DIV0_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
`ifdef MULDIV_DIV0_FLAG_EN
        .div0  (div0),
`endif
        .hi    (hi),
        .lo    (lo)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions.
    function automatic void ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h = 32'd0;
        l = 32'd0;
        case (o)
            3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; end
            3'd2: begin
                if (y == 32'd0) begin
                    // all-ones quotient magnitude, remainder |a|, then signs
                    l = x[31] ? 32'd1 : 32'hFFFFFFFF;
                    h = x;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            3'd3: begin
                if (y == 32'd0) begin
                    l = 32'hFFFFFFFF;
                    h = x;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            default: begin h = 32'd0; l = 32'd0; end
        endcase
    endfunction

    // Behavioural model: a countdown to completion plus the arithmetic above.
    logic        m_busy = 1'b0, m_done = 1'b0, m_div0 = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    logic        p_dz = 1'b0;
    int          rem_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_div0 = 1'b0;
            m_hi = 32'd0; m_lo = 32'd0; rem_cyc = 0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                rem_cyc = 0;
                m_busy  = 1'b0;
            end else if (rem_cyc > 0) begin
                rem_cyc--;
                if (rem_cyc == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (p_dz) m_div0 = 1'b1;
                    else begin m_hi = p_hi; m_lo = p_lo; end
                end
            end else if (start && op <= 3'd5) begin
                m_div0 = 1'b0;
                if (op <= 3'd3) begin
                    ref_calc(op, a, b, p_hi, p_lo);
                    p_dz    = DIV0_EN && (op >= 3'd2) && (b == 32'd0);
                    rem_cyc = p_dz ? 2 : 34;
                    m_busy  = 1'b1;
                end else if (op == 3'd4) begin
                    m_hi = a;
                end else begin
                    m_lo = a;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
`ifdef MULDIV_DIV0_FLAG_EN
            check("div0", {31'd0, div0}, {31'd0, m_div0});
`endif
        end
    end

    // Issue one op at a negedge; returns at the negedge showing done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int bcyc);
        int guard;
        bit got;
        guard = 0;
        while (busy && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) check("idle_wait", {31'd0, busy}, 32'd0);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        bcyc = 0;
        got  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin got = 1'b1; break; end
            if (busy) bcyc++;
            @(negedge clk);
        end
        check("done_seen", {31'd0, got}, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        bit seen;
        logic [31:0] th, tl;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;

        // pin the reference model itself
        ref_calc(3'd2, 32'hFFFFFFF9, 32'd2, th, tl);
        check("ref_div_lo", tl, 32'hFFFFFFFD);
        check("ref_div_hi", th, 32'hFFFFFFFF);
        ref_calc(3'd2, 32'h80000000, 32'hFFFFFFFF, th, tl);
        check("ref_ovf_lo", tl, 32'h80000000);
        check("ref_ovf_hi", th, 32'h00000000);

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFFFFFF, 32'd2, bc);
        check("mult_busy_cycles", bc, 32'd34);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, bc);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);
        run_op(3'd3, 32'd100, 32'd7, bc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, bc);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, bc);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);
        run_op(3'd2, 32'd5, 32'd0, bc);
        if (DIV0_EN) begin
            check("div0_busy_cycles", bc, 32'd2);
            check("div0_lo_kept", lo, 32'h80000000);
            check("div0_hi_kept", hi, 32'h00000000);
`ifdef MULDIV_DIV0_FLAG_EN
            check("div0_flag", {31'd0, div0}, 32'd1);
`endif
        end else begin
            check("div0_busy_cycles", bc, 32'd34);
            check("div0_lo", lo, 32'hFFFFFFFF);
            check("div0_hi", hi, 32'd5);
        end

        // MTLO while idle
        start = 1'b1; op = 3'd5; a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h12345678);
        check("mtlo_done", {31'd0, done}, 32'd0);

        // flush mid-operation, with an ignored start while busy
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_lo", lo, 32'h12345678);
        check("flush_hi", hi, DIV0_EN ? 32'd0 : 32'd5);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= done;
            @(negedge clk);
        end
        check("flush_no_done", {31'd0, seen}, 32'd0);

        // asynchronous reset in the middle of ITER
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 8000; c++) begin
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            a     = pick();
            b     = pick();
            flush = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
